// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 scan-code receiver.
//   ps2_state_e    : receive FSM states
//   PS2_EXT_PREFIX : scan-code prefix marking an extended key (E0)
//   PS2_BRK_PREFIX : scan-code prefix marking a key release (F0)
//   ps2_entry_t    : 10-bit code FIFO entry {ext, brk, code}
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
   localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_entry_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter -- brings the asynchronous PS/2 lines into the clock domain
// and cleans up the PS/2 clock.
//   clock, reset : system clock (rising edge), synchronous active-high reset
//   ps2_clock    : raw PS/2 clock line
//   ps2_data     : raw PS/2 data line
//   data_sync    : 2-FF synchronised data line
//   fall         : one-cycle pulse on each 1->0 step of the filtered clock
//   edge_any     : one-cycle pulse on either step of the filtered clock
// The filtered clock only follows the synchronised line after FILT_LEN
// consecutive samples that disagree with the current filtered level.
module ps2_sync_filter #(
   parameter int FILT_LEN = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic ps2_clock,
   input  logic ps2_data,
   output logic data_sync,
   output logic fall,
   output logic edge_any
);

   localparam int CW = $clog2(FILT_LEN + 1);

   logic          clk_meta_q, clk_sync_q;
   logic          dat_meta_q, dat_sync_q;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fall_q, edge_q;

   // Any sample equal to the filtered level restarts the run length.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (clk_sync_q != filt_q) begin
         if (cnt_q == CW'(FILT_LEN - 1)) filt_d = clk_sync_q;
         else                            cnt_d  = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
         filt_q     <= 1'b1;
         cnt_q      <= '0;
         fall_q     <= 1'b0;
         edge_q     <= 1'b0;
      end else begin
         clk_meta_q <= ps2_clock;
         clk_sync_q <= clk_meta_q;
         dat_meta_q <= ps2_data;
         dat_sync_q <= dat_meta_q;
         filt_q     <= filt_d;
         cnt_q      <= cnt_d;
         fall_q     <= filt_q & ~filt_d;
         edge_q     <= filt_q ^ filt_d;
      end
   end

   assign data_sync = dat_sync_q;
   assign fall      = fall_q;
   assign edge_any  = edge_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx -- PS/2 keyboard frame receiver with prefix folding and a
// show-ahead code FIFO.
//   clock, reset        : system clock (rising edge), sync active-high reset
//   ps2_clock, ps2_data : asynchronous PS/2 lines
//   rd_en               : pop the FIFO head (ignored while valid=0)
//   valid               : FIFO not empty
//   code, brk, ext      : head entry (all zero while valid=0)
//   count               : FIFO occupancy
//   overflow            : sticky, a code was dropped on a full FIFO
//   frame_err           : one-cycle pulse on bad start/parity/stop or timeout
// Build option: define PS2_RX_TIMEOUT_EN to abort a frame after TIMEOUT_CYC
// cycles without a filtered clock edge; without it the FSM waits forever.
module ps2_scan_rx
   import ps2_pkg::*;
#(
   parameter int FILT_LEN    = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          ps2_clock,
   input  logic                          ps2_data,
   input  logic                          rd_en,
   output logic                          valid,
   output logic [7:0]                    code,
   output logic                          brk,
   output logic                          ext,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow,
   output logic                          frame_err
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;

   logic data_s, fall;
`ifdef PS2_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic          filt_edge;
   logic [TW-1:0] tmo_q;
`endif

   ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync (
      .clock     (clock),
      .reset     (reset),
      .ps2_clock (ps2_clock),
      .ps2_data  (ps2_data),
      .data_sync (data_s),
      .fall      (fall),
`ifdef PS2_RX_TIMEOUT_EN
      .edge_any  (filt_edge)
`else
      .edge_any  ()
`endif
   );

   ps2_state_e state_q;
   logic [2:0] bit_idx_q;
   logic [7:0] shreg_q;
   logic       parity_q;
   logic       ext_pend_q, brk_pend_q;
   logic       push_q;
   ps2_entry_t push_entry_q;
   logic       frame_err_q;

   // Receive FSM; shift/parity/entry registers carry data and are not reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_idx_q   <= '0;
         ext_pend_q  <= 1'b0;
         brk_pend_q  <= 1'b0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
         if (state_q == IDLE || filt_edge) tmo_q <= '0;
         else                              tmo_q <= tmo_q + TW'(1);
         if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
         end else
`endif
         if (fall) begin
            unique case (state_q)
               IDLE: begin
                  if (!data_s) begin
                     state_q   <= DATA;
                     bit_idx_q <= '0;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
               DATA: begin
                  shreg_q   <= {data_s, shreg_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) state_q <= PARITY;
               end
               PARITY: begin
                  parity_q <= data_s;
                  state_q  <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  // Odd parity: data bits plus parity bit XOR to 1.
                  if (data_s && ((^shreg_q) ^ parity_q)) begin
                     if (shreg_q == PS2_EXT_PREFIX) begin
                        ext_pend_q <= 1'b1;
                     end else if (shreg_q == PS2_BRK_PREFIX) begin
                        brk_pend_q <= 1'b1;
                     end else begin
                        push_q            <= 1'b1;
                        push_entry_q.ext  <= ext_pend_q;
                        push_entry_q.brk  <= brk_pend_q;
                        push_entry_q.code <= shreg_q;
                        ext_pend_q        <= 1'b0;
                        brk_pend_q        <= 1'b0;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                     ext_pend_q  <= 1'b0;
                     brk_pend_q  <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   ps2_entry_t       mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             overflow_q;
   logic             full, pop, wr_ok;
   ps2_entry_t       head;

   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop   = rd_en && (count_q != '0);
   // A pop on the same edge frees the slot the push needs.
   assign wr_ok = push_q && (!full || pop);

   always_ff @(posedge clock) begin
      if (wr_ok) mem_q[wr_ptr_q] <= push_entry_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push_q && !wr_ok) overflow_q <= 1'b1;
         unique case ({wr_ok, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign valid     = (count_q != '0);
   assign code      = valid ? head.code : 8'h00;
   assign brk       = valid & head.brk;
   assign ext       = valid & head.ext;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx -- directed and randomized bench for ps2_scan_rx.
// A queue-based model of the decoded keyboard stream supplies every
// expected FIFO state; frame_err pulses are counted and compared with the
// number of frames the model classifies as errors.
module tb_ps2_scan_rx;

   localparam int FILT  = 4;
   localparam int DEPTH = 4;
   localparam int TMO   = 200;
   localparam int HALF  = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clock = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd_en = 1'b0;
   logic       valid, brk, ext, overflow, frame_err;
   logic [7:0] code;
   logic [2:0] count;

   ps2_scan_rx #(.FILT_LEN(FILT), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .clock     (clock),
      .reset     (reset),
      .ps2_clock (ps2_clock),
      .ps2_data  (ps2_data),
      .rd_en     (rd_en),
      .valid     (valid),
      .code      (code),
      .brk       (brk),
      .ext       (ext),
      .count     (count),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int ferr_cnt = 0;
   int ferr_exp = 0;

   logic [9:0] mq[$];
   bit m_ext, m_brk, m_ovf;

   always @(negedge clock) if (frame_err === 1'b1) ferr_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Keyboard stream model: prefixes accumulate, a plain code consumes them.
   task automatic model_frame(input logic [7:0] b, input bit bad);
      if (bad) begin
         ferr_exp++;
         m_ext = 0;
         m_brk = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, b});
         else                   m_ovf = 1;
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   task automatic check_state(input string tag);
      logic [9:0] h;
      h = (mq.size() != 0) ? mq[0] : 10'd0;
      check({tag, ".count"}, 32'(count), 32'(mq.size()));
      check({tag, ".valid"}, 32'(valid), 32'(mq.size() != 0));
      check({tag, ".code"},  32'(code),  32'(h[7:0]));
      check({tag, ".brk"},   32'(brk),   32'(h[8]));
      check({tag, ".ext"},   32'(ext),   32'(h[9]));
      check({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
      check({tag, ".ferr"},  32'(ferr_cnt), 32'(ferr_exp));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ps2_clock = 1'b1;
      ps2_data = 1'b1;
      rd_en = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      mq.delete();
      m_ext = 0;
      m_brk = 0;
      m_ovf = 0;
   endtask

   task automatic do_pop();
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
      @(negedge clock);
   endtask

   // One PS/2 bit: data set while the line is high, sampled on the fall.
   // glitch: a FILT-1 cycle low blip in the high phase.
   // pop_here: rd_en on the edge the resulting push lands (2 sync + FILT
   // filter samples + fall pulse + push register after the fall).
   task automatic ps2_bit(input logic v, input bit glitch, input bit pop_here);
      ps2_data = v;
      if (glitch) begin
         repeat (HALF / 2) @(negedge clock);
         ps2_clock = 1'b0;
         repeat (FILT - 1) @(negedge clock);
         ps2_clock = 1'b1;
         repeat (HALF - HALF / 2 - (FILT - 1)) @(negedge clock);
      end else begin
         repeat (HALF) @(negedge clock);
      end
      ps2_clock = 1'b0;
      if (pop_here) begin
         repeat (FILT + 3) @(negedge clock);
         rd_en = 1'b1;
         @(negedge clock);
         rd_en = 1'b0;
         repeat (HALF - FILT - 4) @(negedge clock);
      end else begin
         repeat (HALF) @(negedge clock);
      end
      ps2_clock = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad, input bit glitch, input bit pop_at_stop);
      logic par;
      par = ~(^b) ^ bad;
      ps2_bit(1'b0, glitch, 1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch, 1'b0);
      ps2_bit(par, glitch, 1'b0);
      ps2_bit(1'b1, glitch, pop_at_stop);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clock);
   endtask

   task automatic good(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 1'b0);
      model_frame(b, 1'b0);
   endtask

   initial begin
      logic [7:0] rb, first;
      bit rbad, rgl;
      int r;

      // Reset state
      do_reset();
      check("rst.valid", 32'(valid), 32'd0);
      check("rst.count", 32'(count), 32'd0);
      check("rst.code",  32'(code),  32'd0);
      check("rst.brk_ext", 32'({brk, ext}), 32'd0);
      check("rst.ovf_ferr", 32'({overflow, frame_err}), 32'd0);

      // Single make code
      good(8'h1C);
      check_state("f1c");
      check("f1c.code_k", 32'(code), 32'h1C);
      do_pop();
      check("f1c.pop_valid", 32'(valid), 32'd0);

      // Extended release folds into one entry
      good(8'hE0);
      good(8'hF0);
      check("pref.count_mid", 32'(count), 32'd0);
      good(8'h75);
      check_state("e0f075");
      check("e0f075.k", 32'({ext, brk, code}), 32'h375);
      do_pop();

      // Parity error, then recovery
      send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
      model_frame(8'h1C, 1'b1);
      check_state("perr");
      good(8'h32);
      check_state("after_perr");
      check("after_perr.k", 32'({ext, brk, code}), 32'h032);
      do_pop();

      // Bad start bit from IDLE
      ps2_data = 1'b1;
      ps2_clock = 1'b0;
      repeat (HALF) @(negedge clock);
      ps2_clock = 1'b1;
      repeat (HALF) @(negedge clock);
      ferr_exp++;
      check_state("badstart");

      // Short glitches on every bit must not be sampled
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      model_frame(8'h5A, 1'b0);
      check_state("glitch");
      do_pop();

      // Overflow: DEPTH+1 frames, no reads
      do_reset();
      for (int i = 0; i < DEPTH + 1; i++) good(8'h10 + 8'(i));
      check_state("ovf");
      check("ovf.count_k", 32'(count), 32'(DEPTH));
      check("ovf.flag_k", 32'(overflow), 32'd1);
      check("ovf.head_k", 32'(code), 32'h10);

      // Pop on the final push edge: both succeed, no overflow
      do_reset();
      for (int i = 0; i < DEPTH; i++) good(8'h20 + 8'(i));
      send_frame(8'h2F, 1'b0, 1'b0, 1'b1);
      void'(mq.pop_front());
      model_frame(8'h2F, 1'b0);
      check_state("pushpop");
      check("pushpop.ovf_k", 32'(overflow), 32'd0);
      check("pushpop.head_k", 32'(code), 32'h21);

      // Reset in the middle of a frame
      do_reset();
      first = 8'hA5;
      ps2_bit(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(first[i], 1'b0, 1'b0);
      do_reset();
      good(8'h29);
      check_state("midrst");
      check("midrst.k", 32'({count, code}), 32'h129);

      // Stuck-low clock inside a frame
      first = 8'h5C;
      ps2_bit(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(first[i], 1'b0, 1'b0);
      ps2_data = first[4];
      repeat (HALF) @(negedge clock);
      ps2_clock = 1'b0;
      repeat (TMO + 30) @(negedge clock);
`ifdef PS2_RX_TIMEOUT_EN
      ferr_exp++;
      m_ext = 0;
      m_brk = 0;
      check_state("tmo");
      ps2_clock = 1'b1;
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clock);
      good(8'h3A);
      check_state("after_tmo");
`else
      check_state("stuck");
      do_reset();
`endif

      // Randomized keyboard traffic against the model
      do_reset();
      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, 9));
         rb = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
         rbad = ($urandom_range(0, 7) == 0);
         rgl  = ($urandom_range(0, 3) == 0);
         send_frame(rb, rbad, rgl, 1'b0);
         model_frame(rb, rbad);
         check_state("rnd");
         if ($urandom_range(0, 2) != 0) begin
            do_pop();
            check_state("rnd.pop");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter FILT_LEN, default 8: consecutive equal samples needed to accept a new ps2_clock level.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: code FIFO entries, power of two, >= 2.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000: idle clock cycles allowed inside a frame before abort.
REQ-004 SHALL have port clock, input, 1: sole system clock, rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ps2_clock, input, 1: asynchronous PS/2 clock line.
REQ-007 SHALL have port ps2_data, input, 1: asynchronous PS/2 data line.
REQ-008 SHALL have port rd_en, input, 1: pops the FIFO head when valid=1.
REQ-009 SHALL have port valid, output, 1: FIFO not empty.
REQ-010 SHALL have port code, output, 8: scan code at the FIFO head (show-ahead).
REQ-011 SHALL have port brk, output, 1: head code was preceded by F0 (key release).
REQ-012 SHALL have port ext, output, 1: head code was preceded by E0 (extended key).
REQ-013 SHALL have port count, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
REQ-014 SHALL have port overflow, output, 1: sticky flag; a code was dropped because the FIFO was full.
REQ-015 SHALL have port frame_err, output, 1: one-cycle pulse on a bad start, parity or stop bit, or a timeout.

Function
REQ-016 SHALL pass ps2_clock and ps2_data through 2-FF synchronisers.
REQ-017 SHALL change the filtered clock level only after FILT_LEN consecutive equal synchronised samples.
REQ-018 SHALL generate a one-cycle fall pulse on each 1->0 transition of the filtered clock; all data sampling SHALL occur on that pulse.
REQ-019 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-020 IDLE: on fall with data=0 -> DATA with bit index 0; on fall with data=1 -> stay in IDLE and pulse frame_err.
REQ-021 DATA: shift in data LSB first; after bit 7 -> PARITY.
REQ-022 PARITY: capture the parity bit -> STOP.
REQ-023 STOP: the frame is good iff stop=1 and the XOR of the 8 data bits and parity is 1 (odd parity); the FSM SHALL go to IDLE either way.
REQ-024 Good frame with byte E0: set ext_pend and push nothing.
REQ-025 Good frame with byte F0: set brk_pend and push nothing.
REQ-026 Any other good byte: push {ext_pend, brk_pend, byte} on the cycle after the stop-bit fall pulse, then clear both pend flags.
REQ-027 Bad frame: pulse frame_err, discard the byte, clear both pend flags.
REQ-028 Push while full (with no simultaneous pop): drop the entry, set overflow, leave count unchanged.
REQ-029 rd_en with valid=1 SHALL remove the head on that edge; rd_en with valid=0 SHALL be ignored.
REQ-030 Simultaneous push and pop SHALL both succeed, including when full; count is unchanged.
REQ-031 valid SHALL rise on the cycle after a push into an empty FIFO.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 While valid=0, code, brk and ext SHALL read 0.

Reset
REQ-034 When reset=1 at a rising clock edge: FSM -> IDLE; filtered clock -> 1; FIFO empty; pend flags, overflow, frame_err and valid -> 0; code/brk/ext -> 0; count -> 0.
REQ-035 Reset mid-frame SHALL abandon the partial frame with no push and no frame_err.

Configuration
REQ-036 With PS2_RX_TIMEOUT_EN defined: a counter SHALL clear on every filtered clock edge and while in IDLE.
REQ-037 With PS2_RX_TIMEOUT_EN defined: reaching TIMEOUT_CYC outside IDLE SHALL force IDLE, pulse frame_err, discard the bits and clear the pend flags.
REQ-038 Without PS2_RX_TIMEOUT_EN: no counter SHALL exist and the FSM SHALL wait indefinitely for the next fall.

Structure
REQ-039 Package ps2_pkg SHALL hold the FSM state enum, PS2_EXT_PREFIX=8'hE0, PS2_BRK_PREFIX=8'hF0, and the 10-bit FIFO entry struct {ext, brk, code}.
REQ-040 Sub-module ps2_sync_filter SHALL contain the synchronisers, glitch filter and fall-pulse generator, parametrised by FILT_LEN.
REQ-041 The FSM, prefix logic and FIFO SHALL reside in ps2_scan_rx.

Verification
REQ-042 Frame 1C, parity 0, stop 1 -> valid=1, code=1C, brk=0, ext=0; after rd_en, valid=0.
REQ-043 Frames E0, F0, 75 -> one entry: code=75, ext=1, brk=1; count=1.
REQ-044 Frame 1C with parity 1 -> frame_err pulses once, no push; following frame 32 -> code=32, brk=0, ext=0.
REQ-045 FIFO_DEPTH+1 good frames with no reads -> count=FIFO_DEPTH, overflow=1, head = first code; rd_en on the final push cycle -> no overflow.
REQ-046 Glitches of FILT_LEN-1 cycles on ps2_clock -> no sampling; ps2_clock held low after bit 3 with PS2_RX_TIMEOUT_EN -> frame_err after TIMEOUT_CYC cycles, FSM in IDLE.
REQ-047 reset asserted after bit 4 of a frame, then a clean frame 29 -> exactly one entry, code=29, and no frame_err.
